// File: rtl/mem_access_pkg.sv
// Shared encodings and helpers for the load/store-to-RAM access unit.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_RESP
  } state_e;

  // Lane mask ordered {1h, 1l, 2h, 2l}, i.e. bit 3 is byte addr+0 (big-endian).
  function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] offset);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b1000 >> offset;
      SZ_HALF: m = offset[1] ? 4'b0011 : 4'b1100;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [2:0] size_bytes(input size_e size);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_lane_steer.sv
// Combinational lane steering: store data onto byte lanes, load lanes back into
// extended right-justified data. Lane vectors are packed {1h, 1l, 2h, 2l}.
module mem_lane_steer
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        signed_ld,
  input  logic [31:0] wdata,
  input  logic        wr_active,
  input  logic [31:0] rlanes,
  output logic [31:0] wlanes,
  output logic [3:0]  lane_oe,
  output logic [31:0] rdata
);

  size_e       sz;
  logic [31:0] sh;

  assign sz      = size_e'(size);
  assign lane_oe = wr_active ? lane_mask(sz, offset) : '0;
  // Shifting the addressed bytes to the top makes byte and half extraction offset-free.
  assign sh      = rlanes << {offset, 3'b000};

  always_comb begin
    wlanes = '0;
    rdata  = '0;
    case (sz)
      SZ_BYTE: begin
        wlanes = {4{wdata[7:0]}};
        rdata  = {{24{signed_ld & sh[31]}}, sh[31:24]};
      end
      SZ_HALF: begin
        wlanes = {2{wdata[15:0]}};
        rdata  = {{16{signed_ld & sh[31]}}, sh[31:16]};
      end
      SZ_WORD: begin
        wlanes = wdata;
        rdata  = rlanes;
      end
      default: begin
        wlanes = '0;
        rdata  = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Converts one CPU load/store request into a byte-lane RAM bus transaction
// with alignment/range checking and sign/zero extension of load data.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_rw,
  output logic        mem_en1h,
  output logic        mem_en1l,
  output logic        mem_en2h,
  output logic        mem_en2l,
  inout  logic [7:0]  mem_data1h,
  inout  logic [7:0]  mem_data1l,
  inout  logic [7:0]  mem_data2h,
  inout  logic [7:0]  mem_data2l
);

  state_e      state;
  size_e       size_q;
  logic [1:0]  off_q;
  logic        signed_q;
  logic [31:0] wdata_q;
  logic [3:0]  en_q;

  size_e       req_sz;
  logic        misaligned;
  logic [32:0] req_end;
  logic        req_bad;

  logic [31:0] rlanes;
  logic [31:0] wlanes;
  logic [3:0]  lane_oe;
  logic [31:0] ld_data;

  assign req_sz = size_e'(req_size);

  always_comb begin
    misaligned = 1'b0;
    case (req_sz)
      SZ_HALF: misaligned = req_addr[0];
      SZ_WORD: misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  // One extra bit so addresses near 2^32 cannot wrap back into range.
  assign req_end = {1'b0, req_addr} + {30'd0, size_bytes(req_sz)};
  assign req_bad = (req_sz == SZ_RSVD) || misaligned || (req_end > 33'(MEM_BYTES));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_rw     <= 1'b0;
      en_q       <= '0;
      size_q     <= SZ_BYTE;
      off_q      <= '0;
      signed_q   <= 1'b0;
      wdata_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            size_q     <= req_sz;
            off_q      <= req_addr[1:0];
            signed_q   <= req_signed;
            wdata_q    <= req_wdata;
            req_ready  <= 1'b0;
            resp_rdata <= '0;
            if (req_bad) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              state      <= ST_RESP;
            end else begin
              resp_err <= 1'b0;
              mem_addr <= {req_addr[31:2], 2'b00};
              mem_rw   <= req_write;
              en_q     <= lane_mask(req_sz, req_addr[1:0]);
              state    <= req_write ? ST_WR : ST_RD_ADDR;
            end
          end
        end
        ST_WR: begin
          mem_rw     <= 1'b0;
          en_q       <= '0;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RD_ADDR: begin
          state <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          en_q       <= '0;
          resp_rdata <= ld_data;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          mem_rw    <= 1'b0;
          en_q      <= '0;
        end
      endcase
    end
  end

  assign {mem_en1h, mem_en1l, mem_en2h, mem_en2l} = en_q;
  assign rlanes = {mem_data1h, mem_data1l, mem_data2h, mem_data2l};

  mem_lane_steer u_steer (
    .size      (size_q),
    .offset    (off_q),
    .signed_ld (signed_q),
    .wdata     (wdata_q),
    .wr_active (mem_rw),
    .rlanes    (rlanes),
    .wlanes    (wlanes),
    .lane_oe   (lane_oe),
    .rdata     (ld_data)
  );

  assign mem_data1h = lane_oe[3] ? wlanes[31:24] : 8'bz;
  assign mem_data1l = lane_oe[2] ? wlanes[23:16] : 8'bz;
  assign mem_data2h = lane_oe[1] ? wlanes[15:8]  : 8'bz;
  assign mem_data2l = lane_oe[0] ? wlanes[7:0]   : 8'bz;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit with a byte-array RAM and
// a byte-level reference model.
module tb_mem_access_unit;

  localparam int unsigned MEM_BYTES = 1024;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr;
  logic        mem_rw, mem_en1h, mem_en1l, mem_en2h, mem_en2l;
  wire  [7:0]  d1h, d1l, d2h, d2l;

  mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_rw(mem_rw),
    .mem_en1h(mem_en1h), .mem_en1l(mem_en1l), .mem_en2h(mem_en2h), .mem_en2l(mem_en2l),
    .mem_data1h(d1h), .mem_data1l(d1l), .mem_data2h(d2h), .mem_data2l(d2l)
  );

  always #5 clock = ~clock;

  // Byte-lane RAM: writes commit at negedge, reads register at posedge and drive next cycle.
  logic [7:0]  ram [MEM_BYTES];
  logic [7:0]  ref_mem [MEM_BYTES];
  logic        fill;
  logic        rd_valid;
  logic [31:0] rd_q;
  logic [3:0]  en;

  assign en = {mem_en1h, mem_en1l, mem_en2h, mem_en2l};

  always @(negedge clock) begin
    if (fill) begin
      for (int i = 0; i < MEM_BYTES; i++) ram[i] <= 8'(i * 7 + 3);
    end else if (mem_rw) begin
      if (en[3]) ram[(mem_addr + 0) % MEM_BYTES] <= d1h;
      if (en[2]) ram[(mem_addr + 1) % MEM_BYTES] <= d1l;
      if (en[1]) ram[(mem_addr + 2) % MEM_BYTES] <= d2h;
      if (en[0]) ram[(mem_addr + 3) % MEM_BYTES] <= d2l;
    end
  end

  always @(posedge clock) begin
    rd_valid <= !fill && (|en) && !mem_rw;
    rd_q <= {ram[(mem_addr + 0) % MEM_BYTES], ram[(mem_addr + 1) % MEM_BYTES],
             ram[(mem_addr + 2) % MEM_BYTES], ram[(mem_addr + 3) % MEM_BYTES]};
  end

  assign d1h = (rd_valid && !mem_rw && en[3]) ? rd_q[31:24] : 8'bz;
  assign d1l = (rd_valid && !mem_rw && en[2]) ? rd_q[23:16] : 8'bz;
  assign d2h = (rd_valid && !mem_rw && en[1]) ? rd_q[15:8]  : 8'bz;
  assign d2l = (rd_valid && !mem_rw && en[0]) ? rd_q[7:0]   : 8'bz;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference: byte array, big-endian byte order, plain arithmetic on sizes.
  function automatic void predict(input logic wr, input logic [1:0] sz, input logic sg,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic err, output logic [31:0] rd,
                                  output logic [3:0] lanes, output int lat);
    int unsigned nb;
    logic [31:0] v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    if (nb == 0) err = 1'b1;
    else err = ((a % nb) != 0) || ((64'(a) + 64'(nb)) > 64'(MEM_BYTES));
    rd = '0;
    lanes = '0;
    if (!err) begin
      for (int unsigned k = 0; k < nb; k++) lanes[3 - ((a % 4) + k)] = 1'b1;
      if (wr) begin
        for (int unsigned k = 0; k < nb; k++) ref_mem[a + k] = 8'(wd >> (8 * (nb - 1 - k)));
      end else begin
        v = '0;
        for (int unsigned k = 0; k < nb; k++) v = (v << 8) | 32'(ref_mem[a + k]);
        if (sg && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        rd = v;
      end
    end
    lat = err ? 1 : (wr ? 2 : 3);
  endfunction

  task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd);
    logic e_err, g_err, rw_seen, busy_rdy;
    logic [31:0] e_rd, g_rd;
    logic [3:0] e_en, en_seen;
    int e_lat, g_lat, w;
    predict(wr, sz, sg, a, wd, e_err, e_rd, e_en, e_lat);
    w = 0;
    @(negedge clock);
    while (!req_ready && w < 20) begin
      @(negedge clock);
      w++;
    end
    check({tag, ".rdy"}, {31'd0, req_ready}, 32'd1);
    req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    g_lat = 0; g_err = 1'b0; g_rd = '0; en_seen = '0; rw_seen = 1'b0; busy_rdy = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clock);
      if (resp_valid) begin
        g_lat = n; g_err = resp_err; g_rd = resp_rdata;
        break;
      end
      en_seen |= en;
      rw_seen |= mem_rw;
      busy_rdy |= req_ready;
    end
    check({tag, ".lat"}, 32'(g_lat), 32'(e_lat));
    check({tag, ".err"}, {31'd0, g_err}, {31'd0, e_err});
    check({tag, ".rdata"}, g_rd, e_rd);
    check({tag, ".en"}, {28'd0, en_seen}, {28'd0, e_en});
    check({tag, ".rw"}, {31'd0, rw_seen}, {31'd0, wr && !e_err});
    check({tag, ".busy"}, {31'd0, busy_rdy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic e_err;
    logic [3:0] e_en;
    logic [31:0] rd_a, rd_b, a;
    logic [1:0] sz;
    logic [7:0] rdy_v, rsp_v;
    logic [31:0] got_a, got_b;
    int lat, bad;

    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'(i * 7 + 3);
    fill = 1'b1;
    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = '0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clock);
    check("rst.ready", {31'd0, req_ready}, 32'd1);
    check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst.rdata", resp_rdata, 32'd0);
    check("rst.err", {31'd0, resp_err}, 32'd0);
    check("rst.addr", mem_addr, 32'd0);
    check("rst.bus", {27'd0, mem_rw, en}, 32'd0);
    @(posedge clock);
    #2 fill = 1'b0;
    reset = 1'b1;

    do_req("sw", 1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344);
    do_req("lw", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    check("ram10", {24'd0, ram[16'h10]}, 32'h11);
    check("ram11", {24'd0, ram[16'h11]}, 32'h22);
    check("ram12", {24'd0, ram[16'h12]}, 32'h33);
    check("ram13", {24'd0, ram[16'h13]}, 32'h44);
    do_req("sb", 1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_0080);
    do_req("lbs", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    do_req("lbu", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    check("sb.keep", {ram[16'h10], ram[16'h11], ram[16'h12], ram[16'h13]}, 32'h1122_3380);
    do_req("sh", 1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_BEEF);
    do_req("lhs", 1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
    do_req("e_w6", 1'b0, 2'd2, 1'b0, 32'h6, 32'h0);
    do_req("e_h1", 1'b0, 2'd1, 1'b0, 32'h1, 32'h0);
    do_req("e_rsvd", 1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
    do_req("e_w400", 1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
    do_req("b_sw3fc", 1'b1, 2'd2, 1'b0, MEM_BYTES - 4, 32'hCAFE_F00D);
    do_req("b_lw3fc", 1'b0, 2'd2, 1'b0, MEM_BYTES - 4, 32'h0);
    do_req("b_lb3ff", 1'b0, 2'd0, 1'b1, MEM_BYTES - 1, 32'h0);
    do_req("b_lw3fe", 1'b0, 2'd2, 1'b0, MEM_BYTES - 2, 32'h0);
    do_req("b_sh3fe", 1'b1, 2'd1, 1'b0, MEM_BYTES - 2, 32'h0000_A55A);

    // Reset asserted during the RD_DATA cycle of a load.
    @(negedge clock);
    req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h10;
    req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("mrst.resp_valid", {31'd0, resp_valid}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("mrst.resp_valid2", {31'd0, resp_valid}, 32'd0);
    check("mrst.ready", {31'd0, req_ready}, 32'd1);
    check("mrst.bus", {27'd0, mem_rw, en}, 32'd0);

    for (int t = 0; t < 300; t++) begin
      sz = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: a = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        1: a = MEM_BYTES - 8 + $urandom_range(0, 15);
        default: a = $urandom_range(0, MEM_BYTES - 1);
      endcase
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      do_req("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    // Back-to-back loads with req_valid held high.
    predict(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, e_err, rd_a, e_en, lat);
    predict(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, e_err, rd_b, e_en, lat);
    @(negedge clock);
    req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h20;
    req_valid = 1'b1;
    @(posedge clock);
    #1 req_size = 2'd1; req_signed = 1'b1; req_addr = 32'h22;
    rdy_v = '0; rsp_v = '0; got_a = '0; got_b = '0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clock);
      rdy_v[n - 1] = req_ready;
      rsp_v[n - 1] = resp_valid;
      if (n == 3) got_a = resp_rdata;
      if (n == 7) got_b = resp_rdata;
      if (n == 5) req_valid = 1'b0;
    end
    check("b2b.ready", {24'd0, rdy_v}, 32'h88);
    check("b2b.resp", {24'd0, rsp_v}, 32'h44);
    check("b2b.rd_a", got_a, rd_a);
    check("b2b.rd_b", got_b, rd_b);

    bad = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (ram[i] !== ref_mem[i]) bad++;
    check("ram_image", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
